wb_master_lsu: RTL and testbench

//   Wishbone bus master for CPU load/store traffic; the initiator end of the wishbone_if.

---
 rtl/wb_pkg.sv | 23 ++
 rtl/wishbone_if.sv | 24 ++
 rtl/wb_lane_align.sv | 46 ++++
 rtl/wb_master_lsu.sv | 139 +++++++++++++
 tb/tb_wb_master_lsu.sv | 317 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/wb_pkg.sv
// Shared types for the Wishbone load/store master: access size,
// master FSM states and byte-lane select constants.
package wb_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10
    } size_t;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUS  = 2'b01,
        RESP = 2'b10,
        ERR  = 2'b11
    } state_t;

    localparam logic [3:0] SEL_BYTE0   = 4'b0001;
    localparam logic [3:0] SEL_HALF_LO = 4'b0011;
    localparam logic [3:0] SEL_HALF_HI = 4'b1100;
    localparam logic [3:0] SEL_WORD    = 4'b1111;

endpackage

// File: rtl/wishbone_if.sv
// Wishbone bus bundle: master drives cycle/strobe/write_enable/select/
// address/data_in; slave returns ack and data_out.
interface wishbone_if #(
    parameter int ADDR_WIDTH = 32
);
    logic                  cycle;
    logic                  strobe;
    logic                  write_enable;
    logic [3:0]            select;
    logic [ADDR_WIDTH-1:0] address;
    logic [31:0]           data_in;
    logic                  ack;
    logic [31:0]           data_out;

    modport master (
        output cycle, strobe, write_enable, select, address, data_in,
        input  ack, data_out
    );

    modport slave (
        input  cycle, strobe, write_enable, select, address, data_in,
        output ack, data_out
    );
endinterface

// File: rtl/wb_lane_align.sv
// Byte-lane steering: size/addr_lo/wdata -> select, replicated data_in,
// misaligned; size/addr_lo/is_unsigned/bus_rdata -> extended rdata.
module wb_lane_align
    import wb_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    input  logic        is_unsigned,
    input  logic [31:0] bus_rdata,
    output logic [3:0]  select,
    output logic [31:0] data_in,
    output logic        misaligned,
    output logic [31:0] rdata
);
    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    assign lane_b = bus_rdata[{addr_lo, 3'b000} +: 8];
    assign lane_h = addr_lo[1] ? bus_rdata[31:16] : bus_rdata[15:0];

    always_comb begin
        select     = 4'b0000;
        data_in    = wdata;
        misaligned = 1'b0;
        rdata      = bus_rdata;
        case (size)
            SZ_BYTE: begin
                select  = SEL_BYTE0 << addr_lo;
                data_in = {4{wdata[7:0]}};
                rdata   = {{24{~is_unsigned & lane_b[7]}}, lane_b};
            end
            SZ_HALF: begin
                select     = addr_lo[1] ? SEL_HALF_HI : SEL_HALF_LO;
                data_in    = {2{wdata[15:0]}};
                misaligned = addr_lo[0];
                rdata      = {{16{~is_unsigned & lane_h[15]}}, lane_h};
            end
            SZ_WORD: begin
                select     = SEL_WORD;
                misaligned = |addr_lo;
            end
            default: misaligned = 1'b1;
        endcase
    end
endmodule

// File: rtl/wb_master_lsu.sv
// Wishbone master for CPU loads/stores: one request -> one bus cycle.
// Ports: clk, reset_n, req_* in, resp_* out, wishbone (master modport).
// Optional ack timeout enabled by defining WB_MASTER_TIMEOUT_EN.
module wb_master_lsu
    import wb_pkg::*;
#(
    parameter int ADDR_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [1:0]            req_size,
    input  logic                  req_unsigned,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [31:0]           req_wdata,
    output logic                  resp_valid,
    output logic [31:0]           resp_rdata,
    output logic                  resp_error,
    wishbone_if.master            wishbone
);
    state_t      state;
    logic        lat_write;
    logic [1:0]  lat_size;
    logic [1:0]  lat_addr_lo;
    logic        lat_unsigned;
    logic [1:0]  al_size;
    logic [1:0]  al_addr_lo;
    logic [3:0]  al_select;
    logic [31:0] al_data_in;
    logic        al_misaligned;
    logic [31:0] al_rdata;

    // Live request drives the aligner while idle; latched fields afterwards
    assign al_size    = (state == IDLE) ? req_size : lat_size;
    assign al_addr_lo = (state == IDLE) ? req_addr[1:0] : lat_addr_lo;
    assign req_ready  = (state == IDLE);

    wb_lane_align u_align (
        .size        (al_size),
        .addr_lo     (al_addr_lo),
        .wdata       (req_wdata),
        .is_unsigned (lat_unsigned),
        .bus_rdata   (wishbone.data_out),
        .select      (al_select),
        .data_in     (al_data_in),
        .misaligned  (al_misaligned),
        .rdata       (al_rdata)
    );

`ifdef WB_MASTER_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] wait_cnt;
    logic             timeout_hit;
    assign timeout_hit = (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    // Timeout limit has no effect when the counter is not built
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = |TIMEOUT_CYCLES;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state                 <= IDLE;
            lat_write             <= 1'b0;
            lat_size              <= 2'b00;
            lat_addr_lo           <= 2'b00;
            lat_unsigned          <= 1'b0;
            resp_valid            <= 1'b0;
            resp_error            <= 1'b0;
            resp_rdata            <= '0;
            wishbone.cycle        <= 1'b0;
            wishbone.strobe       <= 1'b0;
            wishbone.write_enable <= 1'b0;
            wishbone.select       <= '0;
            wishbone.address      <= '0;
            wishbone.data_in      <= '0;
`ifdef WB_MASTER_TIMEOUT_EN
            wait_cnt              <= '0;
`endif
        end else begin
            resp_valid <= 1'b0;
            resp_error <= 1'b0;
            unique case (state)
                IDLE: if (req_valid) begin
                    lat_write    <= req_write;
                    lat_size     <= req_size;
                    lat_addr_lo  <= req_addr[1:0];
                    lat_unsigned <= req_unsigned;
                    resp_rdata   <= '0;
                    if (al_misaligned) begin
                        state      <= ERR;
                        resp_valid <= 1'b1;
                        resp_error <= 1'b1;
                    end else begin
                        state                 <= BUS;
                        wishbone.cycle        <= 1'b1;
                        wishbone.strobe       <= 1'b1;
                        wishbone.write_enable <= req_write;
                        wishbone.select       <= al_select;
                        wishbone.address      <=
                            {req_addr[ADDR_WIDTH-1:2], 2'b00};
                        wishbone.data_in      <= al_data_in;
`ifdef WB_MASTER_TIMEOUT_EN
                        wait_cnt              <= '0;
`endif
                    end
                end
                BUS: begin
                    if (wishbone.ack) begin
                        state                 <= RESP;
                        resp_valid            <= 1'b1;
                        wishbone.cycle        <= 1'b0;
                        wishbone.strobe       <= 1'b0;
                        wishbone.write_enable <= 1'b0;
                        if (!lat_write) resp_rdata <= al_rdata;
                    end
`ifdef WB_MASTER_TIMEOUT_EN
                    else if (timeout_hit) begin
                        state                 <= ERR;
                        resp_valid            <= 1'b1;
                        resp_error            <= 1'b1;
                        wishbone.cycle        <= 1'b0;
                        wishbone.strobe       <= 1'b0;
                        wishbone.write_enable <= 1'b0;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
`endif
                end
                RESP:    state <= IDLE;
                ERR:     state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_wb_master_lsu.sv
// Self-checking bench for wb_master_lsu: vector table of single
// accesses plus back-to-back, reset and timeout sequences.
module tb_wb_master_lsu;
    import wb_pkg::*;

    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_unsigned = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_error;

    wishbone_if #(.ADDR_WIDTH(32)) wb ();

    wb_master_lsu #(
        .ADDR_WIDTH     (32),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_write    (req_write),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .resp_valid   (resp_valid),
        .resp_rdata   (resp_rdata),
        .resp_error   (resp_error),
        .wishbone     (wb)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        wr;
        logic [1:0]  sz;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] sdata;
        logic        err;
        logic [3:0]  sel;
        logic [31:0] badr;
        logic [31:0] din;
        logic [31:0] rdata;
    } vec_t;

    vec_t vecs[$];
    int   n_chk = 0;
    int   n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(
        logic wr, logic [1:0] sz, logic uns, logic [31:0] addr,
        logic [31:0] wdata, logic [31:0] sdata, logic err,
        logic [3:0] sel, logic [31:0] badr, logic [31:0] din,
        logic [31:0] rdata);
        vec_t v;
        v.wr = wr; v.sz = sz; v.uns = uns; v.addr = addr;
        v.wdata = wdata; v.sdata = sdata; v.err = err; v.sel = sel;
        v.badr = badr; v.din = din; v.rdata = rdata;
        return v;
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vec_t v;
        int   n;
        logic seen;

        wb.ack = 1'b0;
        wb.data_out = '0;

        //      wr sz    uns addr      wdata         sdata
        //      err sel  badr          din           rdata
        vecs.push_back(mk(1, 2'b00, 0, 32'h103, 32'h0000_00AB, 32'h0,
            0, 4'b1000, 32'h100, 32'hABAB_ABAB, 32'h0));
        vecs.push_back(mk(0, 2'b01, 0, 32'h102, 32'h0, 32'h8001_1234,
            0, 4'b1100, 32'h100, 32'h0, 32'hFFFF_8001));
        vecs.push_back(mk(0, 2'b01, 1, 32'h102, 32'h0, 32'h8001_1234,
            0, 4'b1100, 32'h100, 32'h0, 32'h0000_8001));
        vecs.push_back(mk(0, 2'b10, 0, 32'h101, 32'h0, 32'h0,
            1, 4'b0000, 32'h0, 32'h0, 32'h0));
        vecs.push_back(mk(0, 2'b00, 0, 32'h201, 32'h0, 32'h1234_80FF,
            0, 4'b0010, 32'h200, 32'h0, 32'hFFFF_FF80));
        vecs.push_back(mk(0, 2'b00, 1, 32'h200, 32'h0, 32'hAABB_CCF0,
            0, 4'b0001, 32'h200, 32'h0, 32'h0000_00F0));
        vecs.push_back(mk(1, 2'b01, 0, 32'h010, 32'h1234_5678, 32'h0,
            0, 4'b0011, 32'h010, 32'h5678_5678, 32'h0));
        vecs.push_back(mk(1, 2'b10, 0, 32'h020, 32'hDEAD_BEEF, 32'h0,
            0, 4'b1111, 32'h020, 32'hDEAD_BEEF, 32'h0));
        vecs.push_back(mk(0, 2'b10, 0, 32'h024, 32'h0, 32'h89AB_CDEF,
            0, 4'b1111, 32'h024, 32'h0, 32'h89AB_CDEF));
        vecs.push_back(mk(0, 2'b01, 0, 32'h103, 32'h0, 32'h0,
            1, 4'b0000, 32'h0, 32'h0, 32'h0));
        vecs.push_back(mk(0, 2'b11, 0, 32'h100, 32'h0, 32'h0,
            1, 4'b0000, 32'h0, 32'h0, 32'h0));
        vecs.push_back(mk(1, 2'b01, 0, 32'h001, 32'h0000_FFFF, 32'h0,
            1, 4'b0000, 32'h0, 32'h0, 32'h0));
        vecs.push_back(mk(0, 2'b01, 0, 32'h100, 32'h0, 32'h0000_7FFF,
            0, 4'b0011, 32'h100, 32'h0, 32'h0000_7FFF));
        vecs.push_back(mk(1, 2'b00, 0, 32'h002, 32'h1234_56C3, 32'h0,
            0, 4'b0100, 32'h000, 32'hC3C3_C3C3, 32'h0));

        // Async reset
        #1 reset_n = 1'b0;
        #2;
        chk("rst cycle", 32'(wb.cycle), 0);
        chk("rst strobe", 32'(wb.strobe), 0);
        chk("rst we", 32'(wb.write_enable), 0);
        chk("rst select", 32'(wb.select), 0);
        chk("rst address", wb.address, 0);
        chk("rst data_in", wb.data_in, 0);
        chk("rst resp_valid", 32'(resp_valid), 0);
        chk("rst resp_error", 32'(resp_error), 0);
        chk("rst resp_rdata", resp_rdata, 0);
        #19 reset_n = 1'b1;
        step();
        chk("rst req_ready", 32'(req_ready), 1);

        // Ack outside a bus cycle is ignored
        wb.ack = 1'b1;
        step();
        wb.ack = 1'b0;
        chk("stray ack resp_valid", 32'(resp_valid), 0);
        chk("stray ack cycle", 32'(wb.cycle), 0);

        foreach (vecs[i]) begin
            v = vecs[i];
            req_valid = 1'b1;
            req_write = v.wr;
            req_size = v.sz;
            req_unsigned = v.uns;
            req_addr = v.addr;
            req_wdata = v.wdata;
            @(negedge clk);
            chk($sformatf("v%0d ready", i), 32'(req_ready), 1);
            step();
            req_valid = 1'b0;
            req_addr = '1;
            req_wdata = '1;
            req_size = 2'b10;
            @(negedge clk);
            if (v.err) begin
                chk($sformatf("v%0d err cycle", i), 32'(wb.cycle), 0);
                chk($sformatf("v%0d err valid", i), 32'(resp_valid), 1);
                chk($sformatf("v%0d err flag", i), 32'(resp_error), 1);
                chk($sformatf("v%0d err rdata", i), resp_rdata, 0);
                step();
                @(negedge clk);
                chk($sformatf("v%0d err valid2", i), 32'(resp_valid), 0);
                chk($sformatf("v%0d err cycle2", i), 32'(wb.cycle), 0);
            end else begin
                chk($sformatf("v%0d cycle", i), 32'(wb.cycle), 1);
                chk($sformatf("v%0d strobe", i), 32'(wb.strobe), 1);
                chk($sformatf("v%0d we", i), 32'(wb.write_enable),
                    32'(v.wr));
                chk($sformatf("v%0d select", i), 32'(wb.select),
                    32'(v.sel));
                chk($sformatf("v%0d address", i), wb.address, v.badr);
                chk($sformatf("v%0d data_in", i), wb.data_in, v.din);
                chk($sformatf("v%0d ready busy", i), 32'(req_ready), 0);
                chk($sformatf("v%0d early valid", i),
                    32'(resp_valid), 0);
                wb.ack = 1'b1;
                wb.data_out = v.sdata;
                step();
                wb.ack = 1'b0;
                wb.data_out = 32'h5A5A_5A5A;
                @(negedge clk);
                chk($sformatf("v%0d valid", i), 32'(resp_valid), 1);
                chk($sformatf("v%0d error", i), 32'(resp_error), 0);
                chk($sformatf("v%0d rdata", i), resp_rdata, v.rdata);
                chk($sformatf("v%0d cycle off", i), 32'(wb.cycle), 0);
                chk($sformatf("v%0d strobe off", i), 32'(wb.strobe), 0);
                chk($sformatf("v%0d we off", i),
                    32'(wb.write_enable), 0);
                step();
                @(negedge clk);
                chk($sformatf("v%0d valid2", i), 32'(resp_valid), 0);
                chk($sformatf("v%0d ready2", i), 32'(req_ready), 1);
            end
            step();
        end

        // Back-to-back loads with req_valid held, ack 2 clks after strobe
        req_valid = 1'b1;
        req_write = 1'b0;
        req_size = 2'b10;
        req_unsigned = 1'b0;
        req_addr = 32'h40;
        step();
        req_addr = 32'h44;
        @(negedge clk);
        chk("b2b cycle1", 32'(wb.cycle), 1);
        chk("b2b addr1", wb.address, 32'h40);
        chk("b2b ready busy", 32'(req_ready), 0);
        step();
        wb.ack = 1'b1;
        wb.data_out = 32'h1111_2222;
        @(negedge clk);
        chk("b2b addr held", wb.address, 32'h40);
        chk("b2b ready busy2", 32'(req_ready), 0);
        step();
        wb.ack = 1'b0;
        @(negedge clk);
        chk("b2b valid1", 32'(resp_valid), 1);
        chk("b2b rdata1", resp_rdata, 32'h1111_2222);
        chk("b2b strobe after ack", 32'(wb.strobe), 0);
        chk("b2b ready in resp", 32'(req_ready), 0);
        step();
        @(negedge clk);
        chk("b2b valid1 width", 32'(resp_valid), 0);
        chk("b2b gap cycle", 32'(wb.cycle), 0);
        chk("b2b ready idle", 32'(req_ready), 1);
        step();
        req_valid = 1'b0;
        @(negedge clk);
        chk("b2b cycle2", 32'(wb.cycle), 1);
        chk("b2b addr2", wb.address, 32'h44);
        step();
        wb.ack = 1'b1;
        wb.data_out = 32'h3333_4444;
        step();
        wb.ack = 1'b0;
        @(negedge clk);
        chk("b2b valid2", 32'(resp_valid), 1);
        chk("b2b rdata2", resp_rdata, 32'h3333_4444);
        step();
        @(negedge clk);
        chk("b2b valid2 width", 32'(resp_valid), 0);
        step();

        // Reset while a bus cycle is open
        req_valid = 1'b1;
        req_addr = 32'h80;
        step();
        req_valid = 1'b0;
        #2;
        chk("mid-rst cycle before", 32'(wb.cycle), 1);
        reset_n = 1'b0;
        #1;
        chk("mid-rst cycle", 32'(wb.cycle), 0);
        chk("mid-rst strobe", 32'(wb.strobe), 0);
        wb.ack = 1'b1;
        @(negedge clk);
        reset_n = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 4; k++) begin
            step();
            wb.ack = 1'b0;
            seen |= resp_valid;
        end
        chk("mid-rst no resp", 32'(seen), 0);
        chk("mid-rst ready", 32'(req_ready), 1);

`ifdef WB_MASTER_TIMEOUT_EN
        // Slave never acks: cycle drops after TO bus clocks
        req_valid = 1'b1;
        req_size = 2'b10;
        req_addr = 32'h90;
        step();
        req_valid = 1'b0;
        n = 0;
        while (wb.cycle && n < 3 * TO) begin
            step();
            n++;
        end
        chk("to bus clocks", 32'(n), 32'(TO));
        chk("to valid", 32'(resp_valid), 1);
        chk("to error", 32'(resp_error), 1);
        chk("to rdata", resp_rdata, 0);
        wb.ack = 1'b1;
        wb.data_out = 32'hFFFF_FFFF;
        step();
        wb.ack = 1'b0;
        chk("to late ack valid", 32'(resp_valid), 0);
        chk("to late ack cycle", 32'(wb.cycle), 0);
        step();
        chk("to late ack valid2", 32'(resp_valid), 0);
`else
        n = 0;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
